fetch_queue_ctrl: RTL and testbench

- Instruction fetch sequencer for the Tomasulo front end, placed between the 16-bit instruction ROM and the issue stage.
- Drives the ROM read strobe and absorbs the ROM's one-cycle read latency.
- Buffers fetched words in a first-word-fall-through queue and presents them to issue with a valid/ready handshake, tagged with their program address.
- Stops fetching after a fixed program length; never over-reads the ROM, because ROM reads are destructive (each read advances the ROM address).

---
 rtl/fetch_queue_ctrl.sv | 126 ++++++++++++
 tb/tb_fetch_queue_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_ctrl.sv
// Instruction fetch sequencer: reads a fixed-length program from a destructive-read ROM into a FWFT queue.
// Optional halt-opcode detection is compiled in with FETCH_HALT_DETECT_EN.
module fetch_queue_ctrl #(
  parameter int INSTR_W  = 16,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 4,
  parameter int PROG_LEN = 256
) (
`ifdef FETCH_HALT_DETECT_EN
  output logic                         halt_seen,
`endif
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  output logic                         rom_read,
  input  logic [INSTR_W-1:0]           rom_instruction,
  output logic                         issue_valid,
  output logic [INSTR_W-1:0]           issue_instr,
  output logic [ADDR_W-1:0]            issue_pc,
  input  logic                         issue_ready,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   state_dbg
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W:0] PROG_END = (ADDR_W + 1)'(PROG_LEN);
  localparam logic [CW+1:0]   DEPTH_W  = (CW + 2)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                rom_read_q, rom_read_d;
  logic                rd_pend_q;
  logic [ADDR_W:0]     fetch_cnt_q, fetch_cnt_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [INSTR_W-1:0]  instr_mem [DEPTH];
  logic [ADDR_W-1:0]   pc_mem [DEPTH];
  logic                push, pop, halt_stop;
  logic [CW+1:0]       occ;

  // Issue handshake: the head is offered while issue_valid=1 and held stable
  // until a cycle with issue_valid & issue_ready, where it is consumed.
  assign push = rd_pend_q;
  assign pop  = (count_q != '0) && issue_ready;

  // Occupancy including reads still in flight; keeps the queue from overflowing.
  assign occ = (CW + 2)'(count_q) + (CW + 2)'(rom_read_q) + (CW + 2)'(rd_pend_q)
             - (CW + 2)'(pop);
  assign count_d = count_q + CW'(push) - CW'(pop);

`ifdef FETCH_HALT_DETECT_EN
  logic halt_hit, halt_seen_q;
  assign halt_hit  = push && (rom_instruction[INSTR_W-1 -: 4] == 4'hF);
  assign halt_stop = halt_hit || halt_seen_q;
  assign halt_seen = halt_seen_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      halt_seen_q <= 1'b0;
    else if (halt_hit) halt_seen_q <= 1'b1;
  end
`else
  assign halt_stop = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rom_read_d  = 1'b0;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (fetch_cnt_q == PROG_END || halt_stop) state_d = S_DRAIN;
        else if (fetch_cnt_q < PROG_END && occ < DEPTH_W) rom_read_d = 1'b1;
      end
      S_DRAIN: if (!rom_read_q && !rd_pend_q && count_q == '0) state_d = S_DONE;
      default: state_d = S_DONE;
    endcase
    if (rom_read_d) fetch_cnt_d = fetch_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rom_read_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      fetch_cnt_q <= '0;
      pc_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      rom_read_q  <= rom_read_d;
      rd_pend_q   <= rom_read_q;
      fetch_cnt_q <= fetch_cnt_d;
      count_q     <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        pc_q     <= pc_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= rom_instruction;
      pc_mem[wr_ptr_q]    <= pc_q;
    end
  end

  assign rom_read    = rom_read_q;
  assign issue_valid = (count_q != '0);
  assign issue_instr = issue_valid ? instr_mem[rd_ptr_q] : '0;
  assign issue_pc    = issue_valid ? pc_mem[rd_ptr_q] : '0;
  assign queue_count = count_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Directed bench for fetch_queue_ctrl with a destructive-read ROM model and an issue scoreboard.
module tb_fetch_queue_ctrl;

  localparam int IW  = 16;
  localparam int AW  = 8;
  localparam int DEP = 4;
  localparam int PL  = 6;
  localparam int CW  = $clog2(DEP + 1);

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           issue_ready = 1'b0;
  logic           rom_read;
  logic [IW-1:0]  rom_instruction;
  logic           issue_valid;
  logic [IW-1:0]  issue_instr;
  logic [AW-1:0]  issue_pc;
  logic [CW-1:0]  queue_count;
  logic           busy, done;
  logic [1:0]     state_dbg;
`ifdef FETCH_HALT_DETECT_EN
  logic           halt_seen;
`endif

  logic [IW-1:0]  rom [8];
  logic [AW-1:0]  rom_addr;
  logic [31:0]    exp_q [$];
  int             total = 0;
  int             bad = 0;
  int             rd_pulses, cyc, first_rd, first_v, max_cnt;

  fetch_queue_ctrl #(.INSTR_W(IW), .ADDR_W(AW), .DEPTH(DEP), .PROG_LEN(PL)) dut (
`ifdef FETCH_HALT_DETECT_EN
    .halt_seen(halt_seen),
`endif
    .clock(clock), .reset_n(reset_n), .start(start), .rom_read(rom_read),
    .rom_instruction(rom_instruction), .issue_valid(issue_valid),
    .issue_instr(issue_instr), .issue_pc(issue_pc), .issue_ready(issue_ready),
    .queue_count(queue_count), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clock = ~clock;

  // ROM model: each sampled strobe returns the next word one cycle later and advances the address.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr        <= '0;
      rom_instruction <= '0;
    end else if (rom_read) begin
      rom_instruction <= rom[rom_addr[2:0]];
      rom_addr        <= rom_addr + 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      rd_pulses = 0; cyc = 0; first_rd = -1; first_v = -1; max_cnt = 0;
    end else begin
      cyc++;
      if (rom_read) begin
        rd_pulses++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (issue_valid && first_v < 0) first_v = cyc;
      if (int'(queue_count) > max_cnt) max_cnt = int'(queue_count);
      if (issue_valid && issue_ready) begin
        if (exp_q.size() == 0) chk("extra_issue", 32'(exp_q.size()), 32'd1);
        else chk("issue", {8'h0, issue_pc, issue_instr}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; issue_ready = 1'b0;
    exp_q.delete();
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic load_exp(input int n);
    for (int p = 0; p < n; p++) exp_q.push_back({8'h0, 8'(p), rom[p]});
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (!done && n < max_cyc) begin
      @(posedge clock); #1;
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  initial begin
    rom[0] = 16'h0A01; rom[1] = 16'h01A0; rom[2] = 16'h021A; rom[3] = 16'h0F73;
    rom[4] = 16'hCAAF; rom[5] = 16'h0001; rom[6] = 16'h1111; rom[7] = 16'h2222;

    // Reset state
    #2;
    chk("rst_rom_read", 32'(rom_read), 0);
    chk("rst_outputs", {issue_valid, busy, done, 5'(queue_count), issue_pc, issue_instr}, 0);
    chk("rst_state", 32'(state_dbg), 0);
    do_reset();

    // Streaming with issue_ready held high
    load_exp(PL);
    issue_ready = 1'b1;
    pulse_start();
    wait_done("t1_done", 100);
    chk("t1_latency", 32'(first_v - first_rd), 32'd2);
    chk("t1_left", 32'(exp_q.size()), 0);
    chk("t1_reads", 32'(rd_pulses), 32'd6);
    chk("t1_busy", 32'(busy), 0);

    // Back-pressure: queue fills to DEPTH and fetching stops
    do_reset();
    load_exp(PL);
    pulse_start();
    repeat (20) @(posedge clock);
    #1;
    chk("t2_reads", 32'(rd_pulses), 32'd4);
    chk("t2_count", 32'(queue_count), 32'd4);
    chk("t2_rom_read", 32'(rom_read), 0);
    chk("t2_head", {8'h0, issue_pc, issue_instr}, 32'h0000_0A01);
    repeat (3) @(posedge clock);
    #1;
    chk("t2_head_stable", {7'h0, issue_valid, issue_pc, issue_instr}, 32'h0100_0A01);
    issue_ready = 1'b1;
    wait_done("t2_done", 100);
    chk("t2_left", 32'(exp_q.size()), 0);
    chk("t2_reads_all", 32'(rd_pulses), 32'd6);

    // issue_ready toggling every cycle, pointers wrap
    do_reset();
    load_exp(PL);
    pulse_start();
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clock); #1;
      issue_ready = ~issue_ready;
    end
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_max_count", 32'(max_cnt <= DEP), 32'd1);
    chk("t3_left", 32'(exp_q.size()), 0);
    chk("t3_reads", 32'(rd_pulses), 32'd6);

    // Asynchronous reset in the middle of FETCH
    do_reset();
    pulse_start();
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("t4_async_outputs", {rom_read, issue_valid, busy, done, 4'(queue_count)}, 0);
    chk("t4_async_state", 32'(state_dbg), 0);
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("t4_idle_state", 32'(state_dbg), 0);
    chk("t4_no_reads", 32'(rd_pulses), 0);

    // start ignored during FETCH and DONE
    do_reset();
    load_exp(PL);
    issue_ready = 1'b1;
    pulse_start();
    @(posedge clock);
    pulse_start();
    wait_done("t5_done", 100);
    chk("t5_reads", 32'(rd_pulses), 32'd6);
    chk("t5_left", 32'(exp_q.size()), 0);
    pulse_start();
    repeat (5) @(posedge clock);
    #1;
    chk("t5_done_state", 32'(state_dbg), 32'd3);
    chk("t5_done_reads", 32'(rd_pulses), 32'd6);
    chk("t5_done_busy", {31'h0, busy}, 0);

`ifdef FETCH_HALT_DETECT_EN
    // Halt opcode at address 2
    rom[2] = 16'hF000;
    do_reset();
    load_exp(4);
    issue_ready = 1'b1;
    pulse_start();
    wait_done("t6_done", 100);
    chk("t6_halt_seen", 32'(halt_seen), 32'd1);
    chk("t6_issued_min", 32'(exp_q.size() <= 1), 32'd1);
    chk("t6_reads", 32'(rd_pulses <= 4 && rd_pulses >= 3), 32'd1);
    rom[2] = 16'h021A;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
